// File: rtl/sub1024_pkg.sv
// Shared definitions for the 1024-bit word-serial subtract/compare sequencer.
// Holds the datapath geometry, the mode encodings and the controller state type.
package sub1024_pkg;

  localparam int unsigned W       = 32;  // datapath word width
  localparam int unsigned N_WORDS = 32;  // words per 1024-bit operand
  localparam int unsigned AW      = 5;   // clog2(N_WORDS)

  localparam logic MODE_SUB = 1'b0;      // subtract and write result
  localparam logic MODE_CMP = 1'b1;      // compare only, no writes

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sub_word_borrow.sv
// Combinational W-bit subtract with borrow: {borrow_out, diff} = x - y - borrow_in.
// Ports:
//   x, y       : W-bit operands
//   borrow_in  : incoming borrow from the less significant word
//   diff       : W-bit difference
//   borrow_out : 1 when x < y + borrow_in
module sub_word_borrow #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         borrow_in,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] d;

  // One extra bit on top captures the borrow as the sign of the W+1-bit result.
  always_comb begin
    d          = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, borrow_in};
    diff       = d[W-1:0];
    borrow_out = d[W];
  end

endmodule

// File: rtl/sub1024_seq_ctrl.sv
// Sequences a 1024-bit Z = X - Y as N_WORDS word-serial subtract-with-borrow steps.
// Operand words come from two synchronous RAMs sharing one address; results go to a
// result RAM unless compare mode is selected. Final borrow (X < Y) and all-zero
// (X == Y) flags are reported with a one-cycle done pulse.
// Ports:
//   iClk, iRst       : clock, synchronous active-high reset
//   iStart, iMode    : start request (accepted only when idle), mode (0 sub, 1 cmp)
//   oBusy, oDone     : operation in progress, one-cycle completion pulse
//   oBorrow, oZero   : final borrow and all-zero flags, held until the next completion
//   oRdEn, oRdAddr   : operand RAM read strobe and word address
//   iXWord, iYWord   : operand RAM read data, valid one cycle after oRdEn
//   oWrEn, oWrAddr, oWrData : result RAM write port
module sub1024_seq_ctrl
  import sub1024_pkg::*;
(
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iStart,
  input  logic          iMode,
  output logic          oBusy,
  output logic          oDone,
  output logic          oBorrow,
  output logic          oZero,
  output logic          oRdEn,
  output logic [AW-1:0] oRdAddr,
  input  logic [W-1:0]  iXWord,
  input  logic [W-1:0]  iYWord,
  output logic          oWrEn,
  output logic [AW-1:0] oWrAddr,
  output logic [W-1:0]  oWrData
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_WORDS - 1);

  state_t        state;
  logic          mode_r;
  logic          borrow_r;
  logic          zero_acc;
  logic          cmp_vld;   // operand data on iXWord/iYWord is valid this cycle
  logic [AW-1:0] cmp_addr;  // word index of the data being computed
  logic [W-1:0]  diff;
  logic          diff_borrow;

  sub_word_borrow #(
    .W (W)
  ) u_sub (
    .x          (iXWord),
    .y          (iYWord),
    .borrow_in  (borrow_r),
    .diff       (diff),
    .borrow_out (diff_borrow)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      mode_r   <= MODE_SUB;
      borrow_r <= 1'b0;
      zero_acc <= 1'b1;
      cmp_vld  <= 1'b0;
      cmp_addr <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oBorrow  <= 1'b0;
      oZero    <= 1'b0;
      oRdEn    <= 1'b0;
      oRdAddr  <= '0;
      oWrEn    <= 1'b0;
      oWrAddr  <= '0;
      oWrData  <= '0;
    end else begin
      oDone <= 1'b0;

      // Compute/write pipeline: a read issued this cycle returns data next cycle.
      cmp_vld  <= oRdEn;
      cmp_addr <= oRdAddr;
      if (cmp_vld) begin
        borrow_r <= diff_borrow;
        zero_acc <= zero_acc & (diff == '0);
        oWrEn    <= (mode_r == MODE_SUB);
        if (mode_r == MODE_SUB) begin
          oWrAddr <= cmp_addr;
          oWrData <= diff;
        end
      end else begin
        oWrEn <= 1'b0;
      end

      case (state)
        IDLE: begin
          // cmp_vld is never set in IDLE, so these do not collide with the pipeline.
          if (iStart) begin
            mode_r   <= iMode;
            borrow_r <= 1'b0;
            zero_acc <= 1'b1;
            oBusy    <= 1'b1;
            oRdEn    <= 1'b1;
            oRdAddr  <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (oRdAddr == LAST_ADDR) begin
            oRdEn <= 1'b0;
            state <= DRAIN;
          end else begin
            oRdAddr <= oRdAddr + 1'b1;
          end
        end
        DRAIN: begin
          // Once the compute stage empties, the last word is in the write stage and
          // borrow_r/zero_acc hold their final values.
          if (!cmp_vld) begin
            oBusy   <= 1'b0;
            oDone   <= 1'b1;
            oBorrow <= borrow_r;
            oZero   <= zero_acc;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub1024_seq_ctrl.sv
module tb_sub1024_seq_ctrl;
  import sub1024_pkg::*;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic          iMode;
  logic          oBusy, oDone, oBorrow, oZero, oRdEn, oWrEn;
  logic [AW-1:0] oRdAddr, oWrAddr;
  logic [W-1:0]  iXWord, iYWord, oWrData;

  logic [W-1:0] xmem [N_WORDS];
  logic [W-1:0] ymem [N_WORDS];
  logic [W-1:0] res  [N_WORDS];
  logic [W-1:0] expz [N_WORDS];

  int checks = 0;
  int errors = 0;
  int wcount, dcount, dcyc, bcount, bfirst, blast, rd_bad, post_rst_bad;

  sub1024_seq_ctrl dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iMode   (iMode),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oBorrow (oBorrow),
    .oZero   (oZero),
    .oRdEn   (oRdEn),
    .oRdAddr (oRdAddr),
    .iXWord  (iXWord),
    .iYWord  (iYWord),
    .oWrEn   (oWrEn),
    .oWrAddr (oWrAddr),
    .oWrData (oWrData)
  );

  always #5 iClk = ~iClk;

  // Synchronous operand RAMs: data valid the cycle after the read strobe.
  always @(posedge iClk) begin
    if (oRdEn) begin
      iXWord <= xmem[oRdAddr];
      iYWord <= ymem[oRdAddr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Starts one operation and watches 40 cycles (cycle 1 = cycle after iStart sampled).
  // rst_at / again_at = 0 disables the mid-run reset / second start.
  task automatic run_op(input logic mode, input int rst_at, input int again_at);
    logic exp_rd;
    wcount = 0; dcount = 0; dcyc = 0; bcount = 0; bfirst = 0; blast = 0;
    rd_bad = 0; post_rst_bad = 0;
    for (int i = 0; i < int'(N_WORDS); i++) res[i] = 32'hDEADBEEF;
    @(negedge iClk);
    iStart = 1'b1;
    iMode  = mode;
    for (int c = 1; c <= 40; c++) begin
      @(negedge iClk);
      iStart = 1'b0;
      iRst   = 1'b0;
      if (oWrEn === 1'b1) begin
        wcount++;
        res[oWrAddr] = oWrData;
      end
      if (oDone === 1'b1) begin
        dcount++;
        dcyc = c;
      end
      if (oBusy === 1'b1) begin
        bcount++;
        if (bfirst == 0) bfirst = c;
        blast = c;
      end
      exp_rd = (c <= 32) && !(rst_at != 0 && c > rst_at);
      if (oRdEn !== exp_rd || (exp_rd && oRdAddr !== AW'(c - 1))) rd_bad++;
      if (rst_at != 0 && c > rst_at &&
          ({oBusy, oDone, oBorrow, oZero, oRdEn, oWrEn} !== 6'b0 ||
           oRdAddr !== '0 || oWrAddr !== '0 || oWrData !== '0))
        post_rst_bad++;
      if (c == again_at) begin
        iStart = 1'b1;
        iMode  = ~mode;
      end
      if (c == rst_at) iRst = 1'b1;
    end
  endtask

  task automatic check_op(input string tag, input int exp_writes, input logic exp_b, input logic exp_z);
    chk({tag, "_rd_seq"}, rd_bad, 0);
    chk({tag, "_done_cnt"}, dcount, 1);
    chk({tag, "_done_cyc"}, dcyc, 35);
    chk({tag, "_busy_cnt"}, bcount, 34);
    chk({tag, "_busy_first"}, bfirst, 1);
    chk({tag, "_busy_last"}, blast, 34);
    chk({tag, "_writes"}, wcount, exp_writes);
    chk({tag, "_borrow"}, oBorrow, exp_b);
    chk({tag, "_zero"}, oZero, exp_z);
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < int'(N_WORDS); i++)
      chk($sformatf("%s_word%0d", tag, i), res[i], expz[i]);
  endtask

  task automatic clear_mems;
    for (int i = 0; i < int'(N_WORDS); i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
      expz[i] = '0;
    end
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iMode = 1'b0;
    clear_mems();
    repeat (3) @(negedge iClk);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_borrow", oBorrow, 0);
    chk("rst_zero", oZero, 0);
    chk("rst_rden", oRdEn, 0);
    chk("rst_rdaddr", oRdAddr, 0);
    chk("rst_wren", oWrEn, 0);
    chk("rst_wraddr", oWrAddr, 0);
    chk("rst_wrdata", oWrData, 0);
    iRst = 1'b0;
    @(negedge iClk);

    // 1: X = 1, Y = 0
    clear_mems();
    xmem[0] = 32'h00000001;
    expz[0] = 32'h00000001;
    run_op(MODE_SUB, 0, 0);
    check_op("t1", 32, 1'b0, 1'b0);
    check_words("t1");

    // 2: X = 0, Y = 1 -> borrow ripples through every word
    clear_mems();
    ymem[0] = 32'h00000001;
    for (int i = 0; i < int'(N_WORDS); i++) expz[i] = 32'hFFFFFFFF;
    run_op(MODE_SUB, 0, 0);
    check_op("t2", 32, 1'b1, 1'b0);
    check_words("t2");

    // 3: borrow from word0 into word1
    clear_mems();
    xmem[1] = 32'h00000005;
    ymem[0] = 32'h00000001;
    expz[0] = 32'hFFFFFFFF;
    expz[1] = 32'h00000004;
    run_op(MODE_SUB, 0, 0);
    check_op("t3", 32, 1'b0, 1'b0);
    check_words("t3");

    // 4a: compare, X == Y
    clear_mems();
    for (int i = 0; i < int'(N_WORDS); i++) begin
      ymem[i] = $urandom;
      xmem[i] = ymem[i];
    end
    run_op(MODE_CMP, 0, 0);
    check_op("t4a", 0, 1'b0, 1'b1);

    // 4b: compare, X == Y - 1
    ymem[0] = ymem[0] | 32'h1;
    xmem[0] = ymem[0] - 32'h1;
    run_op(MODE_CMP, 0, 0);
    check_op("t4b", 0, 1'b1, 1'b0);

    // 6: reset at cycle 12 (previous result has oBorrow=1)
    clear_mems();
    xmem[0] = 32'h00000001;
    expz[0] = 32'h00000001;
    run_op(MODE_SUB, 12, 0);
    chk("t6_writes_before_rst", wcount, 10);
    chk("t6_no_done", dcount, 0);
    chk("t6_rd_seq", rd_bad, 0);
    chk("t6_post_rst_outputs", post_rst_bad, 0);
    run_op(MODE_SUB, 0, 0);
    check_op("t6r", 32, 1'b0, 1'b0);
    check_words("t6r");

    // 5: second start at cycle 10 with flipped mode is ignored
    clear_mems();
    xmem[3] = 32'h12345678;
    ymem[3] = 32'h02345670;
    expz[3] = 32'h10000008;
    run_op(MODE_SUB, 0, 10);
    check_op("t5", 32, 1'b0, 1'b0);
    check_words("t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub1024_seq_ctrl.md
Name: sub1024_seq_ctrl

Overview:
- Sequences a 1024-bit multi-precision subtraction (Z = X − Y) as 32 word-serial 32-bit subtract-with-borrow steps.
- Fetches operand words from two synchronous operand RAMs, chains the borrow internally, and writes result words into a result RAM.
- Reports final borrow (X < Y) and an all-zero flag (X == Y).
- Sits between the bus-side command register and the big-number arithmetic memories. Also serves as a compare engine.

Parameters:
- W, 32, datapath word width in bits
- N_WORDS, 32, words per operand (1024/W)
- AW, 5, address width, equal to clog2(N_WORDS)

Ports:
- iClk  input  1  system clock
- iRst  input  1  reset
- iStart  input  1  one-cycle start request
- iMode  input  1  0 = subtract and write result; 1 = compare only, no writes
- oBusy  output  1  operation in progress
- oDone  output  1  one-cycle completion pulse
- oBorrow  output  1  final borrow; 1 means X < Y
- oZero  output  1  1 means every difference word was zero (X == Y)
- oRdEn  output  1  operand RAM read enable
- oRdAddr  output  AW  operand word address, shared by X and Y RAMs
- iXWord  input  W  X RAM read data, valid 1 cycle after oRdEn
- iYWord  input  W  Y RAM read data, valid 1 cycle after oRdEn
- oWrEn  output  1  result RAM write enable
- oWrAddr  output  AW  result word address
- oWrData  output  W  result word

Behaviour:
- Interface (already decided): single clock iClk; iRst is synchronous and active-high.
- All outputs are registered.
- Reset values: oBusy=0, oDone=0, oBorrow=0, oZero=0, oRdEn=0, oRdAddr=0, oWrEn=0, oWrAddr=0, oWrData=0. State=IDLE, borrow register=0, zero accumulator=1.
- States and transitions:
  - IDLE: on iStart=1, latch iMode, clear borrow to 0, set zero accumulator to 1, go to RUN.
  - RUN: issue reads, one address per cycle, 0..N_WORDS−1. After issuing the last address, go to DRAIN.
  - DRAIN: wait until the last write/accumulate completes, then go to DONE.
  - DONE: oDone=1 for exactly one cycle, then go to IDLE.
- Timing, counting the cycle after iStart is sampled as cycle 1, for word i in 0..N_WORDS−1:
  - Read: oRdEn=1, oRdAddr=i in cycle i+1.
  - Compute: iXWord/iYWord for word i are valid in cycle i+2. Compute D = {1'b0,X} − {1'b0,Y} − borrow, W+1 bits wide. Next borrow = D[W]. Zero accumulator &= (D[W−1:0]==0).
  - Write: in cycle i+3, oWrEn=1 (only if latched mode=0), oWrAddr=i, oWrData=D[W−1:0].
- Defaults: oWrEn=0 whenever no write is scheduled. oWrAddr and oWrData hold their last values.
- Default-parameter latency:
  - oBusy=1 in cycles 1..34.
  - oDone=1 in cycle 35.
  - oBorrow and oZero update in cycle 35 and hold until the next accepted start.
  - Generic total latency is N_WORDS+3 cycles.
- Mode handling:
  - iStart while busy, or in the DONE cycle, is ignored. No queuing, no change to the latched mode.
  - iMode is sampled only with an accepted iStart.
  - Compare mode performs identical reads and timing, with oWrEn held 0.
- Counters:
  - Word counter wraps only via state transition. It never addresses beyond N_WORDS−1.
  - A W-bit subtract with zero operands and zero borrow gives D=0 and no borrow.
- Reset mid-operation: iRst returns everything to reset values on the next edge. No further oRdEn/oWrEn and no oDone. oBorrow and oZero return to 0.

Decomposition:
- Package sub1024_pkg:
  - State enum: IDLE, RUN, DRAIN, DONE.
  - Constants: W, N_WORDS, AW.
  - Mode encodings: MODE_SUB=0, MODE_CMP=1.
- One natural sub-module: sub_word_borrow.
  - Combinational W-bit X − Y − borrow-in.
  - Outputs the W-bit difference and borrow-out.
  - Instantiated once in the compute stage.
- The FSM, word counter and pipeline registers stay in sub1024_seq_ctrl.

Test Plan:
1. X = 1 (word0=1, others 0), Y = 0, mode 0 -> 32 writes, word0=00000001, rest 00000000. oDone in cycle 35, oBorrow=0, oZero=0.
2. X = 0, Y = 1, mode 0 -> all 32 words FFFFFFFF, oBorrow=1, oZero=0. Borrow propagates through every word.
3. X word0=00000000, word1=00000005; Y word0=00000001, rest 0 -> word0=FFFFFFFF, word1=00000004, rest 0, oBorrow=0.
4. X = Y = random, mode 1 -> oWrEn never asserted, oZero=1, oBorrow=0. Repeat with X=Y−1 -> oZero=0, oBorrow=1.
5. Second iStart at cycle 10 with iMode flipped -> ignored. Exactly 32 writes, single oDone at cycle 35, original mode honoured.
6. iRst asserted at cycle 12 -> all outputs at reset values from the next cycle. No oDone, no writes after reset. A new iStart afterwards completes normally.
